// File: rtl/fp_pkg.sv
// Shared types and helpers for the pipelined floating-point multiplier.
// Holds the operand/result class encoding, default FP16 field widths,
// and the exponent bias and canonical NaN helper functions.
package fp_pkg;

  typedef enum logic [1:0] {
    FP_ZERO = 2'd0,
    FP_NORM = 2'd1,
    FP_INF  = 2'd2,
    FP_NAN  = 2'd3
  } fp_class_e;

  localparam int unsigned FP16_EXP_W = 5;
  localparam int unsigned FP16_MAN_W = 10;

  // Exponent bias 2^(exp_w-1)-1.
  function automatic int unsigned bias(input int unsigned exp_w);
    return (32'd1 << (exp_w - 1)) - 32'd1;
  endfunction

  // Quiet NaN {0, all-ones exponent, 1 followed by zeros}, right-aligned in 64 bits.
  function automatic logic [63:0] canonical_nan(input int unsigned exp_w,
                                                input int unsigned man_w);
    logic [63:0] v;
    v = ((64'd1 << exp_w) - 64'd1) << man_w;
    v = v | (64'd1 << (man_w - 1));
    return v;
  endfunction

endpackage

// File: rtl/fp_unpack.sv
// Per-operand classifier: splits a word into sign/exponent/fraction,
// classifies it (subnormals flush to zero) and inserts the hidden bit.
// Ports: x (packed operand), cls_c (class), sign_c, exp_c (biased exponent),
//        man_c (hidden bit + fraction). Purely combinational.
module fp_unpack
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = FP16_EXP_W,
  parameter int unsigned MAN_W = FP16_MAN_W
) (
  input  logic [EXP_W+MAN_W:0] x,
  output fp_class_e            cls_c,
  output logic                 sign_c,
  output logic [EXP_W-1:0]     exp_c,
  output logic [MAN_W:0]       man_c
);

  logic [MAN_W-1:0] frac;

  assign sign_c = x[EXP_W+MAN_W];
  assign exp_c  = x[EXP_W+MAN_W-1:MAN_W];
  assign frac   = x[MAN_W-1:0];

  // Classify on exponent extremes; hidden bit only for normal numbers.
  always_comb begin
    cls_c = FP_NORM;
    if (exp_c == '0) begin
      cls_c = FP_ZERO;
    end else if (exp_c == '1) begin
      cls_c = (frac == '0) ? FP_INF : FP_NAN;
    end
    man_c = {(cls_c == FP_NORM), frac};
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready handshake.
// S1 unpack/classify/exponent sum/mantissa product, S2 normalise (+guard/sticky),
// S3 round, range check and pack. All stages advance together.
// Build option: FP_MUL_RNE_EN selects round-to-nearest-even; otherwise truncate.
// Ports: clk, rst (async, active-high), in_valid/in_ready, a, b,
//        out_valid/out_ready, result, flag_ovf, flag_uf, flag_nan.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = FP16_EXP_W,
  parameter int unsigned MAN_W = FP16_MAN_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic                 flag_ovf,
  output logic                 flag_uf,
  output logic                 flag_nan
);

  localparam int unsigned W    = 1 + EXP_W + MAN_W;
  localparam int unsigned EW2  = EXP_W + 2;
  localparam int unsigned PW   = 2 * MAN_W + 2;
  localparam int unsigned BIAS = bias(EXP_W);
  localparam logic [W-1:0] QNAN = W'(canonical_nan(EXP_W, MAN_W));
  localparam logic signed [EW2-1:0] E_MAX  = $signed(EW2'((32'd1 << EXP_W) - 32'd1));
  localparam logic signed [EW2-1:0] E_ZERO = '0;
`ifdef FP_MUL_RNE_EN
  localparam int unsigned SP_W = PW;
`else
  localparam int unsigned SP_W = MAN_W + 2;
`endif

  logic advance;

  fp_class_e        ca, cb, kind_c;
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W:0]   ma, mb;

  logic                  s1_valid, s1_sign;
  fp_class_e             s1_kind;
  logic signed [EW2-1:0] s1_exp;
  logic [SP_W-1:0]       s1_prod;

  logic                  s2_valid, s2_sign;
  fp_class_e             s2_kind;
  logic signed [EW2-1:0] s2_exp;
  logic [MAN_W-1:0]      s2_frac;
  logic                  norm_c;
  logic [MAN_W-1:0]      frac_c;
`ifdef FP_MUL_RNE_EN
  logic                  s2_guard, s2_sticky, guard_c, sticky_c;
`endif

  logic                  carry_c;
  logic [MAN_W-1:0]      frac_r_c;
  logic signed [EW2-1:0] e3_c;
  logic [W-1:0]          res_c;
  logic                  ovf_c, uf_c, nan_c;

  // Whole pipe moves unless a held result is blocking the output.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
    .x(a), .cls_c(ca), .sign_c(sa), .exp_c(ea), .man_c(ma)
  );
  fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
    .x(b), .cls_c(cb), .sign_c(sb), .exp_c(eb), .man_c(mb)
  );

  // Special-case resolution; NaN wins, then 0 x inf, then inf, then zero.
  always_comb begin
    kind_c = FP_NORM;
    if (ca == FP_NAN || cb == FP_NAN) begin
      kind_c = FP_NAN;
    end else if ((ca == FP_INF && cb == FP_ZERO) || (ca == FP_ZERO && cb == FP_INF)) begin
      kind_c = FP_NAN;
    end else if (ca == FP_INF || cb == FP_INF) begin
      kind_c = FP_INF;
    end else if (ca == FP_ZERO || cb == FP_ZERO) begin
      kind_c = FP_ZERO;
    end
  end

  // S1 register: without rounding only the top MAN_W+2 product bits are kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_kind  <= FP_ZERO;
      s1_sign  <= 1'b0;
      s1_exp   <= '0;
      s1_prod  <= '0;
    end else if (advance) begin
      s1_valid <= in_valid;
      s1_kind  <= kind_c;
      s1_sign  <= sa ^ sb;
      s1_exp   <= $signed(EW2'(ea)) + $signed(EW2'(eb)) - $signed(EW2'(BIAS));
`ifdef FP_MUL_RNE_EN
      s1_prod  <= PW'(ma) * PW'(mb);
`else
      s1_prod  <= SP_W'((PW'(ma) * PW'(mb)) >> MAN_W);
`endif
    end
  end

  // Normalise on the product MSB.
  always_comb begin
    norm_c = s1_prod[SP_W-1];
`ifdef FP_MUL_RNE_EN
    frac_c   = norm_c ? s1_prod[2*MAN_W:MAN_W+1] : s1_prod[2*MAN_W-1:MAN_W];
    guard_c  = norm_c ? s1_prod[MAN_W] : s1_prod[MAN_W-1];
    sticky_c = norm_c ? (|s1_prod[MAN_W-1:0]) : (|s1_prod[MAN_W-2:0]);
`else
    frac_c   = norm_c ? s1_prod[MAN_W:1] : s1_prod[MAN_W-1:0];
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      s2_kind   <= FP_ZERO;
      s2_sign   <= 1'b0;
      s2_exp    <= '0;
      s2_frac   <= '0;
`ifdef FP_MUL_RNE_EN
      s2_guard  <= 1'b0;
      s2_sticky <= 1'b0;
`endif
    end else if (advance) begin
      s2_valid  <= s1_valid;
      s2_kind   <= s1_kind;
      s2_sign   <= s1_sign;
      s2_exp    <= s1_exp + $signed(EW2'(norm_c));
      s2_frac   <= frac_c;
`ifdef FP_MUL_RNE_EN
      s2_guard  <= guard_c;
      s2_sticky <= sticky_c;
`endif
    end
  end

  // Round, range-check and pack. A rounding carry leaves frac at zero and bumps e.
  always_comb begin
`ifdef FP_MUL_RNE_EN
    {carry_c, frac_r_c} = {1'b0, s2_frac} +
                          (MAN_W+1)'(s2_guard & (s2_sticky | s2_frac[0]));
`else
    carry_c  = 1'b0;
    frac_r_c = s2_frac;
`endif
    e3_c  = s2_exp + $signed(EW2'(carry_c));
    res_c = '0;
    ovf_c = 1'b0;
    uf_c  = 1'b0;
    nan_c = 1'b0;
    case (s2_kind)
      FP_NAN: begin
        res_c = QNAN;
        nan_c = 1'b1;
      end
      FP_INF:  res_c = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      FP_ZERO: res_c = {s2_sign, {(W-1){1'b0}}};
      default: begin
        if (e3_c >= E_MAX) begin
          res_c = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          ovf_c = 1'b1;
        end else if (e3_c <= E_ZERO) begin
          res_c = {s2_sign, {(W-1){1'b0}}};
          uf_c  = 1'b1;
        end else begin
          res_c = {s2_sign, e3_c[EXP_W-1:0], frac_r_c};
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      flag_ovf  <= 1'b0;
      flag_uf   <= 1'b0;
      flag_nan  <= 1'b0;
    end else if (advance) begin
      out_valid <= s2_valid;
      result    <= res_c;
      flag_ovf  <= s2_valid & ovf_c;
      flag_uf   <= s2_valid & uf_c;
      flag_nan  <= s2_valid & nan_c;
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed self-checking bench for fp_mul_pipe at FP16 defaults.
module tb_fp_mul_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        flag_ovf;
  logic        flag_uf;
  logic        flag_nan;

  int tests;
  int fails;

  fp_mul_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .flag_ovf(flag_ovf), .flag_uf(flag_uf), .flag_nan(flag_nan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Send one operand pair and wait (bounded) for its result; lat counts
  // cycles from the accepting edge to the cycle out_valid is seen.
  task automatic run_op(input logic [15:0] va, input logic [15:0] vb,
                        output logic [15:0] res, output logic [2:0] flg,
                        output int lat);
    @(negedge clk);
    a = va;
    b = vb;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    res = result;
    flg = {flag_nan, flag_ovf, flag_uf};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset in_ready: got %b expected 1", in_ready); end
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset out_valid: got %b expected 0", out_valid); end
    tests++;
    if (result !== 16'h0000) begin fails++; $display("FAIL reset result: got %h expected 0000", result); end
    tests++;
    if ({flag_nan, flag_ovf, flag_uf} !== 3'b000) begin
      fails++; $display("FAIL reset flags: got %b expected 000", {flag_nan, flag_ovf, flag_uf});
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Vector table; flags packed as {nan, ovf, uf}.
  task automatic test_vectors();
    logic [15:0] va [9];
    logic [15:0] vb [9];
    logic [15:0] vr [9];
    logic [2:0]  vf [9];
    logic [15:0] res;
    logic [2:0]  flg;
    int          lat;
    va = '{16'h3E00, 16'hBC00, 16'h3E01, 16'h7BFF, 16'h0400, 16'h7C00, 16'h7C00, 16'h8000, 16'h7E55};
    vb = '{16'h3E00, 16'h4000, 16'h3E01, 16'h4000, 16'h3800, 16'h0000, 16'hC000, 16'h3C00, 16'h3C00};
    vr = '{16'h4080, 16'hC000, 16'h4081, 16'h7C00, 16'h0000, 16'h7E00, 16'hFC00, 16'h8000, 16'h7E00};
    vf = '{3'b000,   3'b000,   3'b000,   3'b010,   3'b001,   3'b100,   3'b000,   3'b000,   3'b100};
`ifdef FP_MUL_RNE_EN
    vr[2] = 16'h4082;
`endif
    for (int i = 0; i < 9; i++) begin
      run_op(va[i], vb[i], res, flg, lat);
      tests++;
      if (res !== vr[i]) begin fails++; $display("FAIL vec%0d result: got %h expected %h", i, res, vr[i]); end
      tests++;
      if (flg !== vf[i]) begin fails++; $display("FAIL vec%0d flags: got %b expected %b", i, flg, vf[i]); end
      tests++;
      if (lat != 3) begin fails++; $display("FAIL vec%0d latency: got %0d expected 3", i, lat); end
    end
  endtask

  // 8 ops streamed; out_ready low in stream cycles 4..7.
  task automatic test_back_to_back();
    logic [15:0] exp_q [8];
    logic [15:0] prev_res, cap;
    logic        stalled_prev, fire_in, fire_out, dup;
    int          sent, recv;
    for (int i = 0; i < 8; i++) exp_q[i] = 16'h4000 + 16'(i << 10);
    sent = 0;
    recv = 0;
    stalled_prev = 1'b0;
    prev_res = '0;
    for (int cyc = 0; cyc < 40 && recv < 8; cyc++) begin
      @(negedge clk);
      in_valid  = (sent < 8);
      a         = 16'h3C00 + 16'(sent << 10);
      b         = 16'h4000;
      out_ready = !(cyc >= 4 && cyc <= 7);
      #1;
      if (out_valid && !out_ready) begin
        tests++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL b2b in_ready cyc%0d: got %b expected 0", cyc, in_ready); end
        if (stalled_prev) begin
          tests++;
          if (result !== prev_res) begin fails++; $display("FAIL b2b stall hold cyc%0d: got %h expected %h", cyc, result, prev_res); end
        end
        stalled_prev = 1'b1;
        prev_res = result;
      end else begin
        stalled_prev = 1'b0;
      end
      fire_in  = in_valid && in_ready;
      fire_out = out_valid && out_ready;
      cap      = result;
      @(posedge clk);
      if (fire_out) begin
        tests++;
        if (recv >= 8) begin
          fails++; $display("FAIL b2b extra result: got %h expected none", cap);
        end else if (cap !== exp_q[recv]) begin
          fails++; $display("FAIL b2b order%0d: got %h expected %h", recv, cap, exp_q[recv]);
        end
        recv++;
      end
      if (fire_in) sent++;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tests++;
    if (recv != 8) begin fails++; $display("FAIL b2b count: got %0d expected 8", recv); end
    dup = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid) dup = 1'b1;
    end
    tests++;
    if (dup !== 1'b0) begin fails++; $display("FAIL b2b duplicate: got out_valid=1 expected 0"); end
  endtask

  // Reset with three ops in flight, then confirm a clean restart.
  task automatic test_reset_mid();
    logic [15:0] res;
    logic [2:0]  flg;
    logic        stale;
    int          lat;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = 16'h3E00;
      b = 16'h3E00;
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_mid out_valid: got %b expected 0", out_valid); end
    tests++;
    if (result !== 16'h0000) begin fails++; $display("FAIL rst_mid result: got %h expected 0000", result); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    stale = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    tests++;
    if (stale !== 1'b0) begin fails++; $display("FAIL rst_mid stale: got out_valid=1 expected 0"); end
    run_op(16'hBC00, 16'h4000, res, flg, lat);
    tests++;
    if (res !== 16'hC000) begin fails++; $display("FAIL rst_mid next result: got %h expected c000", res); end
    tests++;
    if (lat != 3) begin fails++; $display("FAIL rst_mid next latency: got %0d expected 3", lat); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
